// File: rtl/conv_filter_scheduler_pkg.sv
// Shared types and helpers for the convolution filter scheduler.
package conv_filter_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/conv_filter_scheduler_if.sv
// Sequencer, engine-pool and output-buffer signals of the filter scheduler.
interface conv_filter_scheduler_if
  import conv_filter_scheduler_pkg::*;
#(
  parameter int unsigned K       = 6,
  parameter int unsigned NUM_ENG = 2,
  parameter int unsigned FIDX_W  = clog2_min1(K),
  parameter int unsigned EIDX_W  = clog2_min1(NUM_ENG)
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic [NUM_ENG-1:0]        eng_start;
  logic [NUM_ENG*FIDX_W-1:0] eng_filter_idx;
  logic [NUM_ENG-1:0]        eng_done;
  logic                      wr_en;
  logic [EIDX_W-1:0]         wr_engine;
  logic [FIDX_W-1:0]         wr_filter_idx;
  logic                      err;

  modport master (
    input  start, eng_done,
    output busy, done, eng_start, eng_filter_idx, wr_en, wr_engine,
           wr_filter_idx, err
  );

  modport slave (
    output start, eng_done,
    input  busy, done, eng_start, eng_filter_idx, wr_en, wr_engine,
           wr_filter_idx, err
  );
endinterface

// File: rtl/conv_filter_scheduler_prio_pick.sv
// Lowest-index-first picker: flags any request and returns the lowest set index.
module conv_prio_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  output logic          valid_c,
  output logic [IW-1:0] idx_c
);

  always_comb begin
    valid_c = |req;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx_c = IW'(i);
    end
  end

endmodule

// File: rtl/conv_filter_scheduler.sv
// Dispatches K filters over NUM_ENG engines and serialises their results
// into the output buffer, one write per cycle.
module conv_filter_scheduler
  import conv_filter_scheduler_pkg::*;
#(
  parameter int unsigned K       = 6,
  parameter int unsigned NUM_ENG = 2,
  parameter int unsigned FIDX_W  = clog2_min1(K),
  parameter int unsigned EIDX_W  = clog2_min1(NUM_ENG)
) (
  input logic                     clk,
  input logic                     reset,
  conv_filter_scheduler_if.master bus
);

  localparam int unsigned     CNT_W = FIDX_W + 1;
  localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

  state_e                    state, state_nxt;
  logic [CNT_W-1:0]          next_filt, written;
  logic [NUM_ENG-1:0]        eng_busy, pend, eng_start_q;
  logic [FIDX_W-1:0]         filt_q [NUM_ENG];
  logic [NUM_ENG*FIDX_W-1:0] fidx_flat;
  logic                      busy_q, done_q, wr_en_q, err_q;
  logic [EIDX_W-1:0]         wr_engine_q;
  logic [FIDX_W-1:0]         wr_filter_q;

  logic                      accept_c, dispatch_c;
  logic                      idle_valid_c, pend_valid_c;
  logic [EIDX_W-1:0]         idle_idx_c, pend_idx_c;
  logic [NUM_ENG-1:0]        idle_req_c, done_ok_c, done_bad_c, disp_vec_c, wr_vec_c;

  assign idle_req_c = ~eng_busy & ~pend;
  assign done_ok_c  = bus.eng_done & eng_busy;
  assign done_bad_c = bus.eng_done & ~eng_busy;

  conv_prio_pick #(.N(NUM_ENG), .IW(EIDX_W)) u_idle_pick (
    .req     (idle_req_c),
    .valid_c (idle_valid_c),
    .idx_c   (idle_idx_c)
  );

  conv_prio_pick #(.N(NUM_ENG), .IW(EIDX_W)) u_pend_pick (
    .req     (pend),
    .valid_c (pend_valid_c),
    .idx_c   (pend_idx_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, layer accept and dispatch qualification.
  always_comb begin
    state_nxt  = state;
    accept_c   = 1'b0;
    dispatch_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept_c  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (next_filt == K_CNT) state_nxt = DRAIN;
        else                    dispatch_c = idle_valid_c;
      end
      DRAIN: begin
        if ((written == K_CNT) && (pend == '0)) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    disp_vec_c = '0;
    wr_vec_c   = '0;
    if (dispatch_c)   disp_vec_c[idle_idx_c] = 1'b1;
    if (pend_valid_c) wr_vec_c[pend_idx_c]   = 1'b1;
  end

  // Engine bookkeeping, write port and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_filt   <= '0;
      written     <= '0;
      eng_busy    <= '0;
      pend        <= '0;
      eng_start_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_engine_q <= '0;
      wr_filter_q <= '0;
      err_q       <= 1'b0;
      for (int e = 0; e < int'(NUM_ENG); e++) filt_q[e] <= '0;
    end else begin
      eng_busy    <= (eng_busy & ~done_ok_c) | disp_vec_c;
      pend        <= (pend & ~wr_vec_c) | done_ok_c;
      eng_start_q <= disp_vec_c;
      busy_q      <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done_q      <= (state_nxt == FIN);
      wr_en_q     <= pend_valid_c;
      err_q       <= (accept_c ? 1'b0 : err_q) | (|done_bad_c);
      if (pend_valid_c) begin
        wr_engine_q <= pend_idx_c;
        wr_filter_q <= filt_q[pend_idx_c];
      end
      if (accept_c) begin
        next_filt <= '0;
        written   <= '0;
      end else begin
        if (dispatch_c)   next_filt <= next_filt + CNT_W'(1);
        if (pend_valid_c) written   <= written + CNT_W'(1);
      end
      for (int e = 0; e < int'(NUM_ENG); e++) begin
        if (disp_vec_c[e]) filt_q[e] <= next_filt[FIDX_W-1:0];
      end
    end
  end

  always_comb begin
    fidx_flat = '0;
    for (int e = 0; e < int'(NUM_ENG); e++) fidx_flat[e*FIDX_W +: FIDX_W] = filt_q[e];
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.eng_start      = eng_start_q;
  assign bus.eng_filter_idx = fidx_flat;
  assign bus.wr_en          = wr_en_q;
  assign bus.wr_engine      = wr_engine_q;
  assign bus.wr_filter_idx  = wr_filter_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Directed bench: a K=6 and a K=5 scheduler, each with two modelled engines.
module tb_conv_filter_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]      start_v;
  logic [1:0][1:0] eng_done_v;
  wire  [1:0]      busy_v, done_v, wr_en_v, err_v, wr_eng_v;
  wire  [1:0][1:0] eng_start_v;
  wire  [1:0][5:0] efi_v;
  wire  [1:0][2:0] wfi_v;

  conv_filter_scheduler_if #(.K(6), .NUM_ENG(2)) bus6 ();
  conv_filter_scheduler_if #(.K(5), .NUM_ENG(2)) bus5 ();

  assign bus6.start     = start_v[0];
  assign bus6.eng_done  = eng_done_v[0];
  assign busy_v[0]      = bus6.busy;
  assign done_v[0]      = bus6.done;
  assign wr_en_v[0]     = bus6.wr_en;
  assign err_v[0]       = bus6.err;
  assign wr_eng_v[0]    = bus6.wr_engine;
  assign eng_start_v[0] = bus6.eng_start;
  assign efi_v[0]       = bus6.eng_filter_idx;
  assign wfi_v[0]       = bus6.wr_filter_idx;

  assign bus5.start     = start_v[1];
  assign bus5.eng_done  = eng_done_v[1];
  assign busy_v[1]      = bus5.busy;
  assign done_v[1]      = bus5.done;
  assign wr_en_v[1]     = bus5.wr_en;
  assign err_v[1]       = bus5.err;
  assign wr_eng_v[1]    = bus5.wr_engine;
  assign eng_start_v[1] = bus5.eng_start;
  assign efi_v[1]       = bus5.eng_filter_idx;
  assign wfi_v[1]       = bus5.wr_filter_idx;

  conv_filter_scheduler #(.K(6), .NUM_ENG(2)) dut6 (.clk(clk), .reset(reset), .bus(bus6));
  conv_filter_scheduler #(.K(5), .NUM_ENG(2)) dut5 (.clk(clk), .reset(reset), .bus(bus5));

  int   n_vec = 0;
  int   n_err = 0;
  int   lat [2];
  int   cnt [2][2];
  logic outst [2][2];
  logic spur [2][2];
  int   disp_e [2][16], disp_f [2][16], disp_c [2][16], n_disp [2];
  int   wr_e [2][16], wr_f [2][16], wr_c [2][16], n_wr [2];
  int   done_cnt [2], done_c [2];
  int   exp_eng [6] = '{0, 1, 0, 1, 0, 1};
  int   c0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Engine model and event logger, evaluated on every falling edge.
  initial begin : monitor
    logic [1:0] nd;
    eng_done_v = '0;
    for (int d = 0; d < 2; d++)
      for (int e = 0; e < 2; e++) begin
        cnt[d][e] = 0; outst[d][e] = 1'b0; spur[d][e] = 1'b0;
      end
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int d = 0; d < 2; d++)
          for (int e = 0; e < 2; e++) begin
            cnt[d][e] = 0; outst[d][e] = 1'b0;
          end
        eng_done_v = '0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          nd = '0;
          for (int e = 0; e < 2; e++) begin
            if (cnt[d][e] > 0) begin
              cnt[d][e]--;
              if (cnt[d][e] == 0) begin
                nd[e] = 1'b1;
                outst[d][e] = 1'b1;
              end
            end
          end
          for (int e = 0; e < 2; e++) begin
            if (eng_start_v[d][e]) begin
              chk("redispatch_before_write", 32'(outst[d][e]), 0);
              if (n_disp[d] < 16) begin
                disp_e[d][n_disp[d]] = e;
                disp_f[d][n_disp[d]] = int'(efi_v[d][e*3 +: 3]);
                disp_c[d][n_disp[d]] = cyc;
              end
              n_disp[d]++;
              cnt[d][e] = lat[e];
            end
          end
          if (wr_en_v[d]) begin
            if (n_wr[d] < 16) begin
              wr_e[d][n_wr[d]] = int'(wr_eng_v[d]);
              wr_f[d][n_wr[d]] = int'(wfi_v[d]);
              wr_c[d][n_wr[d]] = cyc;
            end
            n_wr[d]++;
            outst[d][wr_eng_v[d]] = 1'b0;
          end
          if (done_v[d]) begin
            done_cnt[d]++;
            done_c[d] = cyc;
          end
          for (int e = 0; e < 2; e++) begin
            if (spur[d][e]) begin
              nd[e] = 1'b1;
              spur[d][e] = 1'b0;
            end
          end
          eng_done_v[d] = nd;
        end
      end
    end
  end

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      n_disp[d] = 0; n_wr[d] = 0; done_cnt[d] = 0; done_c[d] = 0;
    end
  endtask

  task automatic launch(input int d, output int t0);
    @(negedge clk); #1 start_v[d] = 1'b1;
    @(negedge clk); #1 start_v[d] = 1'b0;
    t0 = cyc;
    chk("busy_after_start", 32'(busy_v[d]), 1);
    chk("no_eng_start_yet", 32'(eng_start_v[d]), 0);
  endtask

  task automatic wait_done(input int d, input int limit);
    int n;
    n = 0;
    while (done_cnt[d] == 0 && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt[d] != 0), 1);
    chk("busy_low_after_done", 32'(busy_v[d]), 0);
    repeat (3) @(negedge clk);
    #1 chk("done_once", 32'(done_cnt[d]), 1);
  endtask

  task automatic check_seq(input int d, input int k, input int t0, input int done_rel);
    chk("n_dispatch", 32'(n_disp[d]), 32'(k));
    chk("n_writes", 32'(n_wr[d]), 32'(k));
    chk("first_start_lat", 32'(disp_c[d][0] - t0), 1);
    for (int i = 0; i < k; i++) begin
      chk("disp_filter", 32'(disp_f[d][i]), 32'(i));
      chk("disp_engine", 32'(disp_e[d][i]), 32'(exp_eng[i]));
      chk("wr_filter", 32'(wr_f[d][i]), 32'(i));
      chk("wr_engine", 32'(wr_e[d][i]), 32'(exp_eng[i]));
    end
    chk("done_after_last_wr", 32'(done_c[d] - wr_c[d][k-1]), 1);
    chk("done_latency", 32'(done_c[d] - t0), 32'(done_rel));
    chk("err_clear", 32'(err_v[d]), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy_v[0]), 0);
    chk({tag, "_done"}, 32'(done_v[0]), 0);
    chk({tag, "_eng_start"}, 32'(eng_start_v[0]), 0);
    chk({tag, "_eng_fidx"}, 32'(efi_v[0]), 0);
    chk({tag, "_wr_en"}, 32'(wr_en_v[0]), 0);
    chk({tag, "_wr_engine"}, 32'(wr_eng_v[0]), 0);
    chk({tag, "_wr_fidx"}, 32'(wfi_v[0]), 0);
    chk({tag, "_err"}, 32'(err_v[0]), 0);
  endtask

  initial begin : stim
    int n;
    reset   = 1'b1;
    start_v = '0;
    lat[0]  = 10;
    lat[1]  = 10;
    clear_logs();
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    #1 reset = 1'b0;

    // Baseline layer, both engines at 10 cycles.
    clear_logs();
    launch(0, c0);
    wait_done(0, 200);
    check_seq(0, 6, c0, 41);

    // Both engines finish together: back-to-back writes, engine 0 first.
    lat[0] = 11;
    clear_logs();
    launch(0, c0);
    wait_done(0, 200);
    check_seq(0, 6, c0, 44);
    chk("same_cycle_wr0_time", 32'(wr_c[0][0] - c0), 14);
    chk("same_cycle_wr1_time", 32'(wr_c[0][1] - c0), 15);
    lat[0] = 10;

    // K=5: the last filter goes to engine 0 only.
    clear_logs();
    launch(1, c0);
    wait_done(1, 200);
    check_seq(1, 5, c0, 40);

    // Spurious completion on an idle engine.
    clear_logs();
    @(negedge clk); #1 spur[0][1] = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("spurious_err_set", 32'(err_v[0]), 1);
    repeat (5) @(negedge clk);
    #1 chk("spurious_err_sticky", 32'(err_v[0]), 1);
    chk("spurious_no_write", 32'(n_wr[0]), 0);
    launch(0, c0);
    chk("err_cleared_by_start", 32'(err_v[0]), 0);
    wait_done(0, 200);
    check_seq(0, 6, c0, 41);

    // Reset after three results, then a clean rerun.
    clear_logs();
    launch(0, c0);
    n = 0;
    while (n_wr[0] < 3 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("three_written", 32'(n_wr[0]), 3);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk); #1 reset = 1'b0;
    clear_logs();
    launch(0, c0);
    wait_done(0, 200);
    check_seq(0, 6, c0, 41);

    // Start pulses while busy are ignored.
    clear_logs();
    launch(0, c0);
    repeat (4) @(negedge clk);
    #1 start_v[0] = 1'b1;
    @(negedge clk); #1 start_v[0] = 1'b0;
    repeat (14) @(negedge clk);
    #1 start_v[0] = 1'b1;
    @(negedge clk); #1 start_v[0] = 1'b0;
    wait_done(0, 200);
    check_seq(0, 6, c0, 41);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_filter_scheduler.md
Name: conv_filter_scheduler

Overview:
- Dispatches the K filters of one convolution layer across a pool of NUM_ENG single-filter convolution engines.
- Each engine has a start/done handshake; the scheduler does not rely on fixed cycle counts.
- Captures each engine's finished result into the layer output buffer through a one-write-per-cycle port, then signals layer completion.
- Sits between the layer sequencer (start/done) and the engine pool plus output buffer.

Parameters:
- K, 6, number of filters in the layer (>=1)
- NUM_ENG, 2, number of convolution engines (>=1, <=K)
- FIDX_W, $clog2(K) with minimum 1, width of a filter index
- EIDX_W, $clog2(NUM_ENG) with minimum 1, width of an engine index

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  one-cycle request to process a layer; honoured only in IDLE
- busy  out  1  high from the cycle after an accepted start until done is pulsed
- done  out  1  one-cycle pulse when all K results are written
- eng_start  out  NUM_ENG  one-cycle start pulse per engine
- eng_filter_idx  out  NUM_ENG*FIDX_W  filter index assigned to each engine; engine e uses slice [e*FIDX_W +: FIDX_W]; held stable while that engine is busy
- eng_done  in  NUM_ENG  one-cycle completion pulse per engine
- wr_en  out  1  output-buffer write strobe
- wr_engine  out  EIDX_W  engine whose result is to be copied
- wr_filter_idx  out  FIDX_W  destination filter slot in the output buffer
- err  out  1  sticky protocol-error flag

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk.
- Reset values: busy=0, done=0, eng_start=0, eng_filter_idx=0, wr_en=0, wr_engine=0, wr_filter_idx=0, err=0.
- Internal state also cleared by reset: next_filt=0, written=0, per-engine eng_busy=0 and pend=0.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 moves to RUN and clears next_filt, written and err.
  - start in any other state is ignored.
- Dispatch (RUN):
  - Each cycle, the lowest-indexed engine with eng_busy=0 and pend=0 receives next_filt.
  - eng_start[e] is pulsed, eng_filter_idx[e] is loaded, eng_busy[e] is set and next_filt is incremented.
  - At most one dispatch per cycle.
  - When next_filt reaches K, the FSM moves to DRAIN.
- Completion:
  - eng_done[e] while eng_busy[e]=1 clears eng_busy[e] and sets pend[e].
  - eng_done[e] while eng_busy[e]=0 is ignored and sets err.
  - Multiple eng_done bits in the same cycle are all latched.
- Write arbitration:
  - Each cycle, if any pend bit is set, the lowest-indexed pending engine e is serviced.
  - Serviced outputs: wr_en=1, wr_engine=e, wr_filter_idx=eng_filter_idx[e]. pend[e] is cleared and written is incremented.
  - wr_en and the output fields are registered, so they appear one cycle after pend is seen.
  - An engine is re-dispatched no earlier than the cycle after its pend clears, so its result is never overwritten before capture.
- Same-cycle events:
  - Dispatch and write may occur in the same cycle on different engines.
  - An eng_done and a dispatch to the same engine in the same cycle cannot occur, because dispatch requires eng_busy=0.
- DRAIN: when written reaches K with no pend bits set, the FSM moves to FIN.
- FIN:
  - done=1 for exactly one cycle and busy=0 from that cycle onward.
  - The FSM returns to IDLE the next cycle.
- Latency:
  - First eng_start is 1 cycle after start is accepted.
  - done is 1 cycle after the final wr_en.
- K not a multiple of NUM_ENG: the surplus engines stay idle in the last round; no special handling.
- Reset mid-operation: all state and outputs return to reset values immediately. Engines are expected to be reset by the same signal.
- Widths: counters are FIDX_W+1 bits so they can hold the value K without wrap.

Decomposition:
- Shared package: FSM state enum; helper function clog2_min1 used for FIDX_W and EIDX_W.
- Natural sub-module: conv_prio_pick, a parameterised lowest-index-first picker (request vector in; valid and index out).
- conv_prio_pick is instantiated twice: once for idle-engine selection, once for pending-write selection.

Test Plan:
- K=6, NUM_ENG=2; each engine returns eng_done 10 cycles after eng_start:
  - Filters 0..5 are dispatched alternately to engines 0 and 1.
  - Six wr_en pulses occur with wr_filter_idx {0,1,2,3,4,5}, each paired with the correct engine.
  - done pulses once; err=0.
- Both engines pulse eng_done in the same cycle:
  - Writes occur on consecutive cycles, engine 0 first then engine 1.
  - Neither engine is re-dispatched before its own write.
- K=5, NUM_ENG=2:
  - Engine 1 receives only filters 1 and 3; filter 4 goes to engine 0.
  - done follows the 5th write.
- Spurious eng_done[1] while engine 1 is idle:
  - err=1 and stays sticky until the next accepted start.
  - The write count is unaffected.
- Assert reset while 3 of 6 results have been written:
  - All outputs return to reset values within the same cycle.
  - A subsequent start rerun completes all 6 filters from index 0.
- Pulse start while busy:
  - It is ignored; the filter sequence and done timing are unchanged.
